// File: rtl/serializer_if.sv
// rtl/serializer_if.sv - handshake bundle between a word producer, the serializer and a chunk consumer
//
// Purpose : groups the parallel-input and chunk-output handshakes of the serializer.
// Signals : input_data/input_valid/input_ready   - parallel word handshake
//           output_data/output_valid/output_ready - chunk handshake
//           output_last                           - final chunk of the current word
// Modports: slave  - the serializer's view
//           master - the surrounding logic's view (drives words, consumes chunks)
interface serializer_if #(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1
);
  logic [WIDTH-1:0] input_data;
  logic             input_valid;
  logic             input_ready;
  logic [SHIFT-1:0] output_data;
  logic             output_valid;
  logic             output_ready;
  logic             output_last;

  modport slave (
    input  input_data, input_valid, output_ready,
    output input_ready, output_data, output_valid, output_last
  );

  modport master (
    output input_data, input_valid, output_ready,
    input  input_ready, output_data, output_valid, output_last
  );
endinterface

// File: rtl/serializer.sv
// rtl/serializer.sv - parallel word to SHIFT-bit chunk serializer, least significant chunk first
//
// Purpose : loads a WIDTH-bit word and emits it as WIDTH/SHIFT chunks, marking the
//           final chunk with output_last; accepts the next word on the last-chunk
//           handshake so consecutive words stream without a bubble.
// Ports   : clock - rising-edge clock
//           reset - asynchronous active-high reset
//           bus   - serializer_if.slave (input and output handshakes)
// Params  : WIDTH (word bits), SHIFT (chunk bits, divides WIDTH),
//           PAD_VALUE (bit shifted into vacated MSBs)
module serializer #(
  parameter int         WIDTH     = 8,
  parameter int         SHIFT     = 1,
  parameter logic [0:0] PAD_VALUE = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  serializer_if.slave bus
);

  localparam int CHUNKS = WIDTH / SHIFT;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(CHUNKS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shifted;

  // With one chunk per word there is nothing left to shift in; the register
  // is simply refilled with pad bits.
  generate
    if (SHIFT == WIDTH) begin : g_full
      assign shifted = {WIDTH{PAD_VALUE[0]}};
    end else begin : g_part
      assign shifted = {{SHIFT{PAD_VALUE[0]}}, sh_q[WIDTH-1:SHIFT]};
    end
  endgenerate

  assign bus.output_data = sh_q[SHIFT-1:0];

  always_comb begin
    state_d          = state_q;
    sh_d             = sh_q;
    cnt_d            = cnt_q;
    bus.input_ready  = 1'b1;
    bus.output_valid = 1'b0;
    bus.output_last  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.input_valid) begin
          sh_d    = bus.input_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        bus.output_valid = 1'b1;
        bus.output_last  = (cnt_q == LAST_CNT);
        // A new word is taken only as the last chunk leaves, so ready is a
        // combinational function of the consumer's ready (valid never is).
        bus.input_ready  = (cnt_q == LAST_CNT) && bus.output_ready;
        if (bus.output_ready) begin
          if (cnt_q == LAST_CNT) begin
            if (bus.input_valid) begin
              sh_d  = bus.input_data;
              cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            sh_d  = shifted;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= {WIDTH{PAD_VALUE[0]}};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serializer.sv
// tb/tb_serializer.sv - scoreboard bench for serializer in 8/2/0 and 8/8/1 configurations
module tb_serializer;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  serializer_if #(.WIDTH(8), .SHIFT(2)) ifa ();
  serializer_if #(.WIDTH(8), .SHIFT(8)) ifb ();

  serializer #(.WIDTH(8), .SHIFT(2), .PAD_VALUE(1'b0)) dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (ifa.slave)
  );

  serializer #(.WIDTH(8), .SHIFT(8), .PAD_VALUE(1'b1)) dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (ifb.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // expected chunks: {last, data}
  logic [2:0] exp_a[$];
  logic [8:0] exp_b[$];

  task automatic push_a(input logic [7:0] w);
    for (int i = 0; i < 4; i++) exp_a.push_back({(i == 3), w[2*i +: 2]});
  endtask

  // Samples outputs at the falling edge, then advances past the next rising edge.
  task automatic sample_a(output logic v, output logic l, output logic ir,
                          output logic hs, output logic [1:0] d);
    @(negedge clock);
    v  = ifa.output_valid;
    l  = ifa.output_last;
    ir = ifa.input_ready;
    d  = ifa.output_data;
    hs = ifa.output_valid & ifa.output_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic sample_b(output logic v, output logic l, output logic ir,
                          output logic hs, output logic [7:0] d);
    @(negedge clock);
    v  = ifb.output_valid;
    l  = ifb.output_last;
    ir = ifb.input_ready;
    d  = ifb.output_data;
    hs = ifb.output_valid & ifb.output_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (ifa.output_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got %b exp 0", ifa.output_valid); end
    checks++; if (ifa.output_last  !== 1'b0) begin errors++; $display("FAIL rst_a_last got %b exp 0", ifa.output_last); end
    checks++; if (ifa.input_ready  !== 1'b1) begin errors++; $display("FAIL rst_a_ready got %b exp 1", ifa.input_ready); end
    checks++; if (ifb.output_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid got %b exp 0", ifb.output_valid); end
    checks++; if (ifb.input_ready  !== 1'b1) begin errors++; $display("FAIL rst_b_ready got %b exp 1", ifb.input_ready); end
  endtask

  // Single word, output_ready held high: also used after reset release.
  task automatic test_single(input logic [7:0] w, input string nm);
    logic v, l, ir, hs;
    logic [1:0] d;
    logic [2:0] e;
    ifa.output_ready = 1'b1;
    ifa.input_data   = w;
    ifa.input_valid  = 1'b1;
    for (int k = 0; k < 7; k++) begin
      sample_a(v, l, ir, hs, d);
      if (ir && ifa.input_valid) push_a(ifa.input_data);
      ifa.input_valid = 1'b0;
      ifa.input_data  = 8'h00;
      checks++;
      if (v !== (k >= 1 && k <= 4)) begin errors++; $display("FAIL %s_valid k=%0d got %b exp %b", nm, k, v, (k >= 1 && k <= 4)); end
      checks++;
      if (ir !== (k == 0 || k >= 4)) begin errors++; $display("FAIL %s_in_ready k=%0d got %b exp %b", nm, k, ir, (k == 0 || k >= 4)); end
      if (hs) begin
        checks++;
        if (exp_a.size() == 0) begin errors++; $display("FAIL %s_extra got %b exp none", nm, {l, d}); end
        else begin
          e = exp_a.pop_front();
          if ({l, d} !== e) begin errors++; $display("FAIL %s_chunk k=%0d got %b exp %b", nm, k, {l, d}, e); end
        end
      end
    end
    checks++;
    if (exp_a.size() != 0) begin errors++; $display("FAIL %s_missing got %0d left exp 0", nm, exp_a.size()); end
  endtask

  task automatic test_stall();
    logic v, l, ir, hs;
    logic [1:0] d;
    logic [2:0] e;
    int nhs;
    nhs = 0;
    ifa.input_data  = 8'hB4;
    ifa.input_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      ifa.output_ready = !(k >= 2 && k <= 4);
      sample_a(v, l, ir, hs, d);
      if (ir && ifa.input_valid) push_a(ifa.input_data);
      ifa.input_valid = 1'b0;
      if (k >= 2 && k <= 4) begin
        checks++;
        if ({v, l, d} !== 4'b1001) begin errors++; $display("FAIL stall_hold k=%0d got %b exp 1001", k, {v, l, d}); end
      end
      if (hs) begin
        nhs++;
        checks++;
        if (exp_a.size() == 0) begin errors++; $display("FAIL stall_extra got %b exp none", {l, d}); end
        else begin
          e = exp_a.pop_front();
          if ({l, d} !== e) begin errors++; $display("FAIL stall_chunk k=%0d got %b exp %b", k, {l, d}, e); end
        end
      end
    end
    checks++;
    if (nhs != 4 || exp_a.size() != 0) begin errors++; $display("FAIL stall_count got %0d hs %0d left exp 4 hs 0 left", nhs, exp_a.size()); end
  endtask

  task automatic test_back_to_back();
    logic v, l, ir, hs;
    logic [1:0] d;
    logic [2:0] e;
    int nin;
    nin = 0;
    ifa.output_ready = 1'b1;
    ifa.input_data   = 8'hB4;
    ifa.input_valid  = 1'b1;
    for (int k = 0; k < 11; k++) begin
      sample_a(v, l, ir, hs, d);
      if (ir && ifa.input_valid) begin
        push_a(ifa.input_data);
        nin++;
        if (nin == 1) ifa.input_data = 8'h1E;
        else ifa.input_valid = 1'b0;
      end
      checks++;
      if (v !== (k >= 1 && k <= 8)) begin errors++; $display("FAIL b2b_valid k=%0d got %b exp %b", k, v, (k >= 1 && k <= 8)); end
      checks++;
      if (ir !== (k == 0 || k == 4 || k >= 8)) begin errors++; $display("FAIL b2b_in_ready k=%0d got %b exp %b", k, ir, (k == 0 || k == 4 || k >= 8)); end
      if (hs) begin
        checks++;
        if (exp_a.size() == 0) begin errors++; $display("FAIL b2b_extra got %b exp none", {l, d}); end
        else begin
          e = exp_a.pop_front();
          if ({l, d} !== e) begin errors++; $display("FAIL b2b_chunk k=%0d got %b exp %b", k, {l, d}, e); end
        end
      end
    end
    checks++;
    if (exp_a.size() != 0 || nin != 2) begin errors++; $display("FAIL b2b_missing got %0d left %0d words exp 0 left 2 words", exp_a.size(), nin); end
  endtask

  task automatic test_async_reset();
    logic v, l, ir, hs;
    logic [1:0] d;
    logic [2:0] e;
    ifa.output_ready = 1'b1;
    ifa.input_data   = 8'hB4;
    ifa.input_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample_a(v, l, ir, hs, d);
      if (ir && ifa.input_valid) push_a(ifa.input_data);
      ifa.input_valid = 1'b0;
      if (hs) begin
        checks++;
        e = exp_a.pop_front();
        if ({l, d} !== e) begin errors++; $display("FAIL arst_pre_chunk k=%0d got %b exp %b", k, {l, d}, e); end
      end
    end
    // third chunk is now presented; reset lands between edges
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({ifa.output_valid, ifa.output_last, ifa.input_ready} !== 3'b001) begin
      errors++; $display("FAIL arst_immediate got v/l/r=%b exp 001", {ifa.output_valid, ifa.output_last, ifa.input_ready});
    end
    exp_a.delete();
    @(posedge clock);
    #1;
    checks++;
    if (ifa.output_valid !== 1'b0) begin errors++; $display("FAIL arst_held got %b exp 0", ifa.output_valid); end
    reset = 1'b0;
    test_single(8'hFF, "arst_post");
  endtask

  task automatic test_full_width();
    logic v, l, ir, hs;
    logic [7:0] d;
    logic [8:0] e;
    int nin;
    nin = 0;
    ifb.output_ready = 1'b1;
    ifb.input_data   = 8'h5A;
    ifb.input_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sample_b(v, l, ir, hs, d);
      if (ir && ifb.input_valid) begin
        exp_b.push_back({1'b1, ifb.input_data});
        nin++;
        if (nin == 1) ifb.input_data = 8'hC3;
        else ifb.input_valid = 1'b0;
      end
      checks++;
      if (v !== (k == 1 || k == 2)) begin errors++; $display("FAIL full_valid k=%0d got %b exp %b", k, v, (k == 1 || k == 2)); end
      checks++;
      if (l !== v) begin errors++; $display("FAIL full_last k=%0d got %b exp %b", k, l, v); end
      checks++;
      if (ir !== 1'b1) begin errors++; $display("FAIL full_in_ready k=%0d got %b exp 1", k, ir); end
      if (hs) begin
        checks++;
        if (exp_b.size() == 0) begin errors++; $display("FAIL full_extra got %h exp none", d); end
        else begin
          e = exp_b.pop_front();
          if ({l, d} !== e) begin errors++; $display("FAIL full_chunk k=%0d got %h exp %h", k, {l, d}, e); end
        end
      end
    end
    checks++;
    if (exp_b.size() != 0) begin errors++; $display("FAIL full_missing got %0d left exp 0", exp_b.size()); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    ifa.input_data   = 8'h00;
    ifa.input_valid  = 1'b0;
    ifa.output_ready = 1'b0;
    ifb.input_data   = 8'h00;
    ifb.input_valid  = 1'b0;
    ifb.output_ready = 1'b0;
    #1;
    test_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    test_single(8'hB4, "basic");
    test_stall();
    test_back_to_back();
    test_async_reset();
    test_full_width();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
